// File: rtl/karatsuba_pipe_if.sv
// Handshake and data bundle for karatsuba_pipe: input transaction side and
// registered result side, each with its own valid/ready pair.
interface karatsuba_pipe_if #(
  parameter int W     = 256,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     Xin;
  logic [W-1:0]     Yin;
  logic [1:0]       mode;
  logic [TAG_W-1:0] in_tag;
  logic [2*W-1:0]   P;
  logic [TAG_W-1:0] out_tag;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_valid, Xin, Yin, mode, in_tag, out_ready,
    input  in_ready, P, out_tag, out_valid
  );

  modport slave (
    input  in_valid, Xin, Yin, mode, in_tag, out_ready,
    output in_ready, P, out_tag, out_valid
  );
endinterface

// File: rtl/karatsuba_pipe.sv
// Pipelined one-level Karatsuba multiplier (full / low / high / square) with a
// global stall: every stage, including the output register, moves only when in_ready=1.
module karatsuba_pipe #(
  parameter int W          = 256,
  parameter int MUL_STAGES = 4,
  parameter int TAG_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  karatsuba_pipe_if.slave  bus
);

  localparam int H  = W / 2;
  localparam int ZW = 2 * H;
  localparam int MW = 2 * H + 2;
  localparam int PW = 2 * W;
  localparam int L  = MUL_STAGES - 1;

  logic adv;

  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [H-1:0]     s2_xh_q, s2_xh_d, s2_xl_q, s2_xl_d;
  logic [H-1:0]     s2_yh_q, s2_yh_d, s2_yl_q, s2_yl_d;
  logic [H:0]       s2_sx_q, s2_sx_d, s2_sy_q, s2_sy_d;
  logic [1:0]       s2_mode_q, s2_mode_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic [ZW-1:0] prod_h, prod_l;
  logic [MW-1:0] prod_m;

  logic [MUL_STAGES-1:0]             mv_q, mv_d;
  logic [MUL_STAGES-1:0][ZW-1:0]     mh_q, mh_d, ml_q, ml_d;
  logic [MUL_STAGES-1:0][MW-1:0]     mm_q, mm_d;
  logic [MUL_STAGES-1:0][1:0]        mmode_q, mmode_d;
  logic [MUL_STAGES-1:0][TAG_W-1:0]  mtag_q, mtag_d;

  logic             s4_valid_q, s4_valid_d;
  logic [ZW-1:0]    s4_hi_q, s4_hi_d, s4_lo_q, s4_lo_d;
  logic [MW-1:0]    s4_mid_q, s4_mid_d;
  logic [1:0]       s4_mode_q, s4_mode_d;
  logic [TAG_W-1:0] s4_tag_q, s4_tag_d;

  logic             s5_valid_q, s5_valid_d;
  logic [PW-1:0]    s5_full_q, s5_full_d;
  logic [1:0]       s5_mode_q, s5_mode_d;
  logic [TAG_W-1:0] s5_tag_q, s5_tag_d;

  logic [PW-1:0]    sel_p;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    p_q, p_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.P         = p_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_valid = out_valid_q;

  // The (H+1)-bit half-sums give a product of at most 2H+2 bits, so no carry is dropped.
  assign prod_h = {{H{1'b0}}, s2_xh_q} * {{H{1'b0}}, s2_yh_q};
  assign prod_l = {{H{1'b0}}, s2_xl_q} * {{H{1'b0}}, s2_yl_q};
  assign prod_m = {{(MW-H-1){1'b0}}, s2_sx_q} * {{(MW-H-1){1'b0}}, s2_sy_q};

  // Output mode select: low or high half of the recombined product, or the full product.
  always_comb begin
    case (s5_mode_q)
      2'b01:   sel_p = {{W{1'b0}}, s5_full_q[W-1:0]};
      2'b10:   sel_p = {{W{1'b0}}, s5_full_q[PW-1:W]};
      default: sel_p = s5_full_q;
    endcase
  end

  // Next-state for every stage: advance the whole pipe together or hold it all.
  always_comb begin
    if (adv) begin
      s1_valid_d = bus.in_valid;
      s1_x_d     = bus.Xin;
      s1_y_d     = (bus.mode == 2'b11) ? bus.Xin : bus.Yin;
      s1_mode_d  = bus.mode;
      s1_tag_d   = bus.in_tag;

      s2_valid_d = s1_valid_q;
      s2_xh_d    = s1_x_q[W-1:H];
      s2_xl_d    = s1_x_q[H-1:0];
      s2_yh_d    = s1_y_q[W-1:H];
      s2_yl_d    = s1_y_q[H-1:0];
      s2_sx_d    = {1'b0, s1_x_q[W-1:H]} + {1'b0, s1_x_q[H-1:0]};
      s2_sy_d    = {1'b0, s1_y_q[W-1:H]} + {1'b0, s1_y_q[H-1:0]};
      s2_mode_d  = s1_mode_q;
      s2_tag_d   = s1_tag_q;

      mv_d[0]    = s2_valid_q;
      mh_d[0]    = prod_h;
      ml_d[0]    = prod_l;
      mm_d[0]    = prod_m;
      mmode_d[0] = s2_mode_q;
      mtag_d[0]  = s2_tag_q;
      for (int i = 1; i < MUL_STAGES; i++) begin
        mv_d[i]    = mv_q[i-1];
        mh_d[i]    = mh_q[i-1];
        ml_d[i]    = ml_q[i-1];
        mm_d[i]    = mm_q[i-1];
        mmode_d[i] = mmode_q[i-1];
        mtag_d[i]  = mtag_q[i-1];
      end

      s4_valid_d = mv_q[L];
      s4_hi_d    = mh_q[L];
      s4_lo_d    = ml_q[L];
      s4_mid_d   = mm_q[L] - {2'b00, mh_q[L]} - {2'b00, ml_q[L]};
      s4_mode_d  = mmode_q[L];
      s4_tag_d   = mtag_q[L];

      s5_valid_d = s4_valid_q;
      s5_full_d  = {s4_hi_q, s4_lo_q} + ({{(PW-MW){1'b0}}, s4_mid_q} << H);
      s5_mode_d  = s4_mode_q;
      s5_tag_d   = s4_tag_q;

      // A bubble leaves the last result on P; only out_valid reports it gone.
      out_valid_d = s5_valid_q;
      p_d         = s5_valid_q ? sel_p : p_q;
      out_tag_d   = s5_valid_q ? s5_tag_q : out_tag_q;
    end else begin
      s1_valid_d  = s1_valid_q;
      s1_x_d      = s1_x_q;
      s1_y_d      = s1_y_q;
      s1_mode_d   = s1_mode_q;
      s1_tag_d    = s1_tag_q;
      s2_valid_d  = s2_valid_q;
      s2_xh_d     = s2_xh_q;
      s2_xl_d     = s2_xl_q;
      s2_yh_d     = s2_yh_q;
      s2_yl_d     = s2_yl_q;
      s2_sx_d     = s2_sx_q;
      s2_sy_d     = s2_sy_q;
      s2_mode_d   = s2_mode_q;
      s2_tag_d    = s2_tag_q;
      mv_d        = mv_q;
      mh_d        = mh_q;
      ml_d        = ml_q;
      mm_d        = mm_q;
      mmode_d     = mmode_q;
      mtag_d      = mtag_q;
      s4_valid_d  = s4_valid_q;
      s4_hi_d     = s4_hi_q;
      s4_lo_d     = s4_lo_q;
      s4_mid_d    = s4_mid_q;
      s4_mode_d   = s4_mode_q;
      s4_tag_d    = s4_tag_q;
      s5_valid_d  = s5_valid_q;
      s5_full_d   = s5_full_q;
      s5_mode_d   = s5_mode_q;
      s5_tag_d    = s5_tag_q;
      out_valid_d = out_valid_q;
      p_d         = p_q;
      out_tag_d   = out_tag_q;
    end
  end

  // Control and output registers: cleared by reset so in-flight work is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      mv_q        <= '0;
      s4_valid_q  <= 1'b0;
      s5_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      mv_q        <= mv_d;
      s4_valid_q  <= s4_valid_d;
      s5_valid_q  <= s5_valid_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      out_tag_q   <= out_tag_d;
    end
  end

  // Datapath registers: contents are ignored while their valid bit is low.
  always_ff @(posedge clock) begin
    s1_x_q    <= s1_x_d;
    s1_y_q    <= s1_y_d;
    s1_mode_q <= s1_mode_d;
    s1_tag_q  <= s1_tag_d;
    s2_xh_q   <= s2_xh_d;
    s2_xl_q   <= s2_xl_d;
    s2_yh_q   <= s2_yh_d;
    s2_yl_q   <= s2_yl_d;
    s2_sx_q   <= s2_sx_d;
    s2_sy_q   <= s2_sy_d;
    s2_mode_q <= s2_mode_d;
    s2_tag_q  <= s2_tag_d;
    mh_q      <= mh_d;
    ml_q      <= ml_d;
    mm_q      <= mm_d;
    mmode_q   <= mmode_d;
    mtag_q    <= mtag_d;
    s4_hi_q   <= s4_hi_d;
    s4_lo_q   <= s4_lo_d;
    s4_mid_q  <= s4_mid_d;
    s4_mode_q <= s4_mode_d;
    s4_tag_q  <= s4_tag_d;
    s5_full_q <= s5_full_d;
    s5_mode_q <= s5_mode_d;
    s5_tag_q  <= s5_tag_d;
  end

endmodule

// File: tb/tb_karatsuba_pipe.sv
// Bench for karatsuba_pipe: a W=256/MUL_STAGES=4 instance and a W=64/MUL_STAGES=1
// instance, each checked against a plain-arithmetic product model and an in-order queue.
module tb_karatsuba_pipe;

  typedef struct {
    logic [511:0] p;
    logic [7:0]   tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  karatsuba_pipe_if #(.W(256), .TAG_W(8)) bus_a ();
  karatsuba_pipe_if #(.W(64),  .TAG_W(8)) bus_b ();

  karatsuba_pipe #(.W(256), .MUL_STAGES(4), .TAG_W(8)) dut_a (
    .clock(clk), .reset(rst), .bus(bus_a));
  karatsuba_pipe #(.W(64), .MUL_STAGES(1), .TAG_W(8)) dut_b (
    .clock(clk), .reset(rst), .bus(bus_b));

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int n_acc_a = 0, n_out_a = 0, n_seen_a = 0, run_a = 0, max_run_a = 0;
  int n_acc_b = 0, n_out_b = 0, n_seen_b = 0;
  bit prev_a = 1'b0;

  // Product as the specification defines it, for an operand width w.
  function automatic logic [511:0] ref_model(input logic [255:0] x, input logic [255:0] y,
                                             input logic [1:0] m, input int w);
    logic [511:0] full, mask;
    logic [255:0] yy;
    yy   = (m == 2'b11) ? x : y;
    full = {256'd0, x} * {256'd0, yy};
    mask = (512'd1 << w) - 512'd1;
    case (m)
      2'b01:   return full & mask;
      2'b10:   return (full >> w) & mask;
      default: return full;
    endcase
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    case ($urandom_range(0, 5))
      0:       r = '0;
      1:       r = '1;
      default: for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] r;
    case ($urandom_range(0, 5))
      0:       r = '0;
      1:       r = '1;
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One cycle on instance A: inputs already driven at the negedge.
  task automatic step_a();
    exp_t e;
    #1;
    if (bus_a.out_valid && bus_a.out_ready) begin
      n_seen_a++;
      run_a = prev_a ? run_a + 1 : 1;
      if (run_a > max_run_a) max_run_a = run_a;
      prev_a = 1'b1;
      if (q_a.size() == 0) begin
        chk("a_unexpected_out_valid", {511'd0, bus_a.out_valid}, 512'd0);
      end else begin
        e = q_a.pop_front();
        chk("a_p", bus_a.P, e.p);
        chk("a_tag", {504'd0, bus_a.out_tag}, {504'd0, e.tag});
        n_out_a++;
      end
    end else begin
      prev_a = 1'b0;
    end
    if (bus_a.in_valid && bus_a.in_ready && !rst) begin
      e.p   = ref_model(bus_a.Xin, bus_a.Yin, bus_a.mode, 256);
      e.tag = bus_a.in_tag;
      q_a.push_back(e);
      n_acc_a++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_b();
    exp_t e;
    #1;
    if (bus_b.out_valid && bus_b.out_ready) begin
      n_seen_b++;
      if (q_b.size() == 0) begin
        chk("b_unexpected_out_valid", {511'd0, bus_b.out_valid}, 512'd0);
      end else begin
        e = q_b.pop_front();
        chk("b_p", {384'd0, bus_b.P}, e.p);
        chk("b_tag", {504'd0, bus_b.out_tag}, {504'd0, e.tag});
        n_out_b++;
      end
    end
    if (bus_b.in_valid && bus_b.in_ready && !rst) begin
      e.p   = ref_model({192'd0, bus_b.Xin}, {192'd0, bus_b.Yin}, bus_b.mode, 64);
      e.tag = bus_b.in_tag;
      q_b.push_back(e);
      n_acc_b++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single transaction into an empty A pipe; the accepting edge is edge 1.
  task automatic run_one_a(input logic [255:0] x, input logic [255:0] y, input logic [1:0] m,
                           input logic [7:0] tag, output int lat, output logic [511:0] p,
                           output logic [7:0] t);
    bus_a.Xin = x; bus_a.Yin = y; bus_a.mode = m; bus_a.in_tag = tag;
    bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    lat = 0; p = '0; t = '0;
    for (int k = 2; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus_a.out_valid) begin
        lat = k; p = bus_a.P; t = bus_a.out_tag;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_one_b(input logic [63:0] x, input logic [63:0] y, input logic [1:0] m,
                           input logic [7:0] tag, output int lat, output logic [127:0] p);
    bus_b.Xin = x; bus_b.Yin = y; bus_b.mode = m; bus_b.in_tag = tag;
    bus_b.in_valid = 1'b1; bus_b.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    lat = 0; p = '0;
    for (int k = 2; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus_b.out_valid) begin
        lat = k; p = bus_b.P;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int seen0, acc0, out0, cyc;
    logic [511:0] p, p_hold;
    logic [127:0] pb;
    logic [7:0] t, t_hold;
    logic [255:0] ones;
    logic [63:0] xb, yb;

    rst = 1'b1;
    bus_a.in_valid = 1'b1; bus_a.Xin = '1; bus_a.Yin = '1; bus_a.mode = 2'b00;
    bus_a.in_tag = 8'd7; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b1; bus_b.Xin = '1; bus_b.Yin = '1; bus_b.mode = 2'b00;
    bus_b.in_tag = 8'd7; bus_b.out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("a_reset_p", bus_a.P, 512'd0);
    chk("a_reset_tag", {504'd0, bus_a.out_tag}, 512'd0);
    chk("a_reset_valid", {511'd0, bus_a.out_valid}, 512'd0);
    chk("b_reset_valid", {511'd0, bus_b.out_valid}, 512'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    for (int i = 0; i < 12; i++) step_a();
    chk("a_reset_input_discarded", 512'(n_seen_a), 512'd0);

    // Directed operands with known results and latency.
    ones = '1;
    run_one_a(ones, ones, 2'b00, 8'd5, lat, p, t);
    chk("a_lat_full", 512'(lat), 512'd9);
    chk("a_full_ones", p, 512'd0 - (512'd1 << 257) + 512'd1);
    chk("a_full_tag", {504'd0, t}, 512'd5);
    run_one_a(ones, ones, 2'b01, 8'd6, lat, p, t);
    chk("a_lat_low", 512'(lat), 512'd9);
    chk("a_low_ones", p, 512'd1);
    run_one_a(ones, ones, 2'b10, 8'd7, lat, p, t);
    chk("a_high_ones", p, (512'd1 << 256) - 512'd2);
    run_one_a(256'd3, 256'd5, 2'b11, 8'd8, lat, p, t);
    chk("a_square_3", p, 512'd9);
    chk("a_square_tag", {504'd0, t}, 512'd8);

    // Twenty back-to-back accepts.
    max_run_a = 0; prev_a = 1'b0;
    out0 = n_out_a;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus_a.Xin = rnd256(); bus_a.Yin = rnd256(); bus_a.mode = 2'($urandom_range(0, 3));
      bus_a.in_tag = 8'(i); bus_a.in_valid = 1'b1;
      step_a();
    end
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 15; i++) step_a();
    chk("a_b2b_count", 512'(n_out_a - out0), 512'd20);
    chk("a_b2b_consecutive", 512'(max_run_a), 512'd20);

    // Fill the pipe, then stall the output for five cycles.
    for (int i = 0; i < 12; i++) begin
      bus_a.Xin = rnd256(); bus_a.Yin = rnd256(); bus_a.mode = 2'($urandom_range(0, 3));
      bus_a.in_tag = 8'(100 + i); bus_a.in_valid = 1'b1;
      step_a();
    end
    #1;
    chk("a_stall_start_valid", {511'd0, bus_a.out_valid}, 512'd1);
    p_hold = bus_a.P;
    t_hold = bus_a.out_tag;
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_a();
      #1;
      chk("a_stall_in_ready", {511'd0, bus_a.in_ready}, 512'd0);
      chk("a_stall_p", bus_a.P, p_hold);
      chk("a_stall_tag", {504'd0, bus_a.out_tag}, {504'd0, t_hold});
      chk("a_stall_valid", {511'd0, bus_a.out_valid}, 512'd1);
    end
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step_a();
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 15; i++) step_a();
    chk("a_drain_queue", 512'(q_a.size()), 512'd0);
    chk("a_exactly_once", 512'(n_out_a), 512'(n_acc_a));

    // Reset while four transactions are in flight.
    for (int i = 0; i < 4; i++) begin
      bus_a.Xin = rnd256() | 256'd1; bus_a.Yin = rnd256() | 256'd1;
      bus_a.mode = 2'b00; bus_a.in_tag = 8'(200 + i); bus_a.in_valid = 1'b1;
      step_a();
    end
    bus_a.in_valid = 1'b0;
    step_a();
    step_a();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("a_midreset_valid", {511'd0, bus_a.out_valid}, 512'd0);
    chk("a_midreset_p", bus_a.P, 512'd0);
    @(negedge clk);
    rst = 1'b0;
    q_a.delete();
    seen0 = n_seen_a;
    for (int i = 0; i < 15; i++) step_a();
    chk("a_midreset_no_stale", 512'(n_seen_a - seen0), 512'd0);

    // Narrow instance: unstalled latency per mode, then a long random run.
    for (int m = 0; m < 4; m++) begin
      xb = rnd64(); yb = rnd64();
      run_one_b(xb, yb, 2'(m), 8'(m), lat, pb);
      chk("b_lat", 512'(lat), 512'd6);
      chk("b_directed_p", {384'd0, pb}, ref_model({192'd0, xb}, {192'd0, yb}, 2'(m), 64));
    end
    acc0 = n_acc_b;
    cyc = 0;
    while ((n_acc_b - acc0) < 10000 && cyc < 60000) begin
      bus_b.Xin = rnd64(); bus_b.Yin = rnd64(); bus_b.mode = 2'($urandom_range(0, 3));
      bus_b.in_tag = 8'($urandom); bus_b.in_valid = ($urandom_range(0, 3) != 0);
      bus_b.out_ready = ($urandom_range(0, 2) != 0);
      step_b();
      cyc++;
    end
    chk("b_random_accepts", 512'(n_acc_b - acc0), 512'd10000);
    bus_b.in_valid = 1'b0;
    bus_b.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step_b();
    chk("b_drain_queue", 512'(q_b.size()), 512'd0);
    chk("b_exactly_once", 512'(n_out_b), 512'(n_acc_b));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
